multicycle_sequencer: RTL and testbench

- Multicycle control sequencer for the RISC datapath. Replaces per-instruction single-cycle decoding with an FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the same control-signal set (alu_op, alu_src, mem_to_reg, reg_write, branch resolution) one phase at a time.
- Handshakes with instruction and data memories that may insert wait states, and keeps a retired-instruction count.

---
 rtl/multicycle_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps each instruction through FETCH, DECODE,
// EXEC, MEM and WB. It drives the datapath control signals one phase at a time,
// waits on instruction/data memory ready handshakes, and counts retired
// instructions.
module multicycle_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic [1:0]       reg_write,
    output logic [1:0]       mem_to_reg,
    output logic [2:0]       alu_op,
    output logic             alu_src,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_R0  = 6'b000000;
    localparam logic [5:0] OP_R1  = 6'b000001;
    localparam logic [5:0] OP_R2  = 6'b000010;
    localparam logic [5:0] OP_BZ  = 6'b000011;
    localparam logic [5:0] OP_BN  = 6'b000100;
    localparam logic [5:0] OP_LD  = 6'b000101;
    localparam logic [5:0] OP_ST  = 6'b000110;
    localparam logic [5:0] OP_R7  = 6'b000111;
    localparam logic [5:0] OP_R8  = 6'b001000;
    localparam logic [5:0] OP_JAL = 6'b001001;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       retire;
    logic       br_taken;

    assign state = state_q;

    // State register and opcode latch; the opcode is captured only in DECODE.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    // Next-state and per-phase control outputs; everything held at 0 during reset.
    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = S_FETCH;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        reg_write  = 2'b00;
        mem_to_reg = 2'b00;
        alu_op     = 3'b000;
        alu_src    = 1'b0;
        illegal_op = 1'b0;
        retire     = 1'b0;
        br_taken   = 1'b0;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end

                S_DECODE: begin
                    if (opcode > OP_JAL) begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end

                S_EXEC: begin
                    case (op_q)
                        OP_R0: begin alu_op = 3'b001; alu_src = 1'b1; state_d = S_WB; end
                        OP_R1: begin alu_op = 3'b010; alu_src = 1'b1; state_d = S_WB; end
                        OP_R2: begin alu_op = 3'b011; alu_src = 1'b1; state_d = S_WB; end
                        OP_BZ, OP_BN: begin
                            alu_src  = 1'b1;
                            br_taken = (op_q == OP_BZ) ? alu_zero : alu_neg;
                            if (br_taken) begin
                                pc_write = 1'b1;
                                pc_src   = 2'b01;
                            end
                            retire = 1'b1;
                        end
                        OP_LD: begin alu_op = 3'b100; state_d = S_MEM; end
                        OP_ST: begin alu_op = 3'b101; state_d = S_MEM; end
                        OP_R7: begin alu_op = 3'b110; state_d = S_WB; end
                        OP_R8: begin alu_op = 3'b111; state_d = S_WB; end
                        OP_JAL: begin
                            alu_src  = 1'b1;
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                            state_d  = S_WB;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end

                S_MEM: begin
                    case (op_q)
                        OP_LD: begin
                            dmem_rd = 1'b1;
                            state_d = dmem_ready ? S_WB : S_MEM;
                        end
                        OP_ST: begin
                            dmem_wr = 1'b1;
                            if (dmem_ready) begin
                                retire = 1'b1;
                            end else begin
                                state_d = S_MEM;
                            end
                        end
                        default: state_d = S_FETCH;
                    endcase
                end

                S_WB: begin
                    case (op_q)
                        OP_R0, OP_R1, OP_R2, OP_R7, OP_R8: reg_write = 2'b10;
                        OP_LD: begin
                            reg_write  = 2'b10;
                            mem_to_reg = 2'b01;
                        end
                        OP_JAL: begin
                            reg_write  = 2'b01;
                            mem_to_reg = 2'b10;
                        end
                        default: reg_write = 2'b00;
                    endcase
                    retire = 1'b1;
                end

                default: state_d = S_FETCH;
            endcase
        end
    end

    assign instr_done = retire;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. A per-instruction model expands
// each instruction into its expected cycle-by-cycle outputs; a compare process
// checks the DUT against that list on every falling edge.
module tb_multicycle_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode;
    logic          alu_zero, alu_neg, imem_ready, dmem_ready;
    logic          imem_req, ir_write, pc_write, dmem_rd, dmem_wr;
    logic [1:0]    pc_src, reg_write, mem_to_reg;
    logic [2:0]    alu_op, state;
    logic          alu_src, instr_done, illegal_op;
    logic [CW-1:0] retired_cnt;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [2:0]    st;
        logic          imem_req, ir_write, pc_write;
        logic [1:0]    pc_src;
        logic          dmem_rd, dmem_wr;
        logic [1:0]    reg_write, mem_to_reg;
        logic [2:0]    alu_op;
        logic          alu_src, instr_done, illegal_op;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          q[$];
    logic [CW-1:0] model_cnt;

    multicycle_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .dmem_rd(dmem_rd),
        .dmem_wr(dmem_wr), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .alu_src(alu_src), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic exp_t idle(input logic [2:0] s);
        exp_t e;
        e     = '0;
        e.st  = s;
        e.cnt = model_cnt;
        return e;
    endfunction

    // ALU operation code per defined opcode.
    function automatic logic [2:0] alu_code(input logic [5:0] op);
        case (op)
            6'd0: return 3'b001;
            6'd1: return 3'b010;
            6'd2: return 3'b011;
            6'd5: return 3'b100;
            6'd6: return 3'b101;
            6'd7: return 3'b110;
            6'd8: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue its expectation.
    task automatic cyc(input logic [5:0] opc, input logic ir, input logic dr,
                       input logic z, input logic n, input exp_t e);
        @(posedge clk);
        #1;
        opcode     = opc;
        imem_ready = ir;
        dmem_ready = dr;
        alu_zero   = z;
        alu_neg    = n;
        q.push_back(e);
    endtask

    // Expand one instruction into its expected cycles. iw/dw are memory wait
    // cycles; abort stops after the first data-memory wait cycle.
    task automatic run_instr(input logic [5:0] op, input int iw, input int dw,
                             input logic z, input logic n, input bit abort,
                             output int cycles);
        exp_t e;
        bit   is_ld, is_st, is_br, is_jal;
        cycles = 0;
        is_ld  = (op == 6'd5);
        is_st  = (op == 6'd6);
        is_br  = (op == 6'd3) || (op == 6'd4);
        is_jal = (op == 6'd9);

        for (int i = 0; i < iw; i++) begin
            e = idle(3'd0);
            e.imem_req = 1'b1;
            cyc(r6(), 1'b0, r1(), r1(), r1(), e);
            cycles++;
        end
        e = idle(3'd0);
        e.imem_req = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        cyc(r6(), 1'b1, r1(), r1(), r1(), e);
        cycles++;

        e = idle(3'd1);
        e.illegal_op = (op > 6'd9);
        cyc(op, r1(), r1(), r1(), r1(), e);
        cycles++;
        if (op > 6'd9) return;

        e = idle(3'd2);
        e.alu_op  = alu_code(op);
        e.alu_src = (op <= 6'd4) || is_jal;
        if (is_br) begin
            if ((op == 6'd3) ? z : n) begin
                e.pc_write = 1'b1;
                e.pc_src   = 2'b01;
            end
            e.instr_done = 1'b1;
        end
        if (is_jal) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'b10;
        end
        cyc(r6(), r1(), r1(), z, n, e);
        cycles++;
        if (is_br) begin
            model_cnt++;
            return;
        end

        if (is_ld || is_st) begin
            for (int i = 0; i < dw; i++) begin
                e = idle(3'd3);
                e.dmem_rd = is_ld;
                e.dmem_wr = is_st;
                cyc(r6(), r1(), 1'b0, r1(), r1(), e);
                cycles++;
                if (abort) return;
            end
            e = idle(3'd3);
            e.dmem_rd    = is_ld;
            e.dmem_wr    = is_st;
            e.instr_done = is_st;
            cyc(r6(), r1(), 1'b1, r1(), r1(), e);
            cycles++;
            if (is_st) begin
                model_cnt++;
                return;
            end
        end

        e = idle(3'd4);
        e.instr_done = 1'b1;
        if (is_ld) begin
            e.reg_write  = 2'b10;
            e.mem_to_reg = 2'b01;
        end else if (is_jal) begin
            e.reg_write  = 2'b01;
            e.mem_to_reg = 2'b10;
        end else begin
            e.reg_write = 2'b10;
        end
        cyc(r6(), r1(), r1(), r1(), r1(), e);
        cycles++;
        model_cnt++;
    endtask

    // Compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("state",       32'(state),       32'(e.st));
            check("imem_req",    32'(imem_req),    32'(e.imem_req));
            check("ir_write",    32'(ir_write),    32'(e.ir_write));
            check("pc_write",    32'(pc_write),    32'(e.pc_write));
            check("pc_src",      32'(pc_src),      32'(e.pc_src));
            check("dmem_rd",     32'(dmem_rd),     32'(e.dmem_rd));
            check("dmem_wr",     32'(dmem_wr),     32'(e.dmem_wr));
            check("reg_write",   32'(reg_write),   32'(e.reg_write));
            check("mem_to_reg",  32'(mem_to_reg),  32'(e.mem_to_reg));
            check("alu_op",      32'(alu_op),      32'(e.alu_op));
            check("alu_src",     32'(alu_src),     32'(e.alu_src));
            check("instr_done",  32'(instr_done),  32'(e.instr_done));
            check("illegal_op",  32'(illegal_op),  32'(e.illegal_op));
            check("retired_cnt", 32'(retired_cnt), 32'(e.cnt));
        end
    end

    task automatic run_random(input int count);
        int   c;
        logic [5:0] op;
        for (int k = 0; k < count; k++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(10, 63));
            else                           op = 6'($urandom_range(0, 9));
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), r1(), r1(), 1'b0, c);
        end
    endtask

    initial begin
        int c;
        rst        = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        opcode     = 6'd0;
        alu_zero   = 1'b0;
        alu_neg    = 1'b0;
        model_cnt  = '0;

        repeat (2) @(negedge clk);
        check("rst_state",       32'(state),       32'd0);
        check("rst_imem_req",    32'(imem_req),    32'd0);
        check("rst_ir_write",    32'(ir_write),    32'd0);
        check("rst_pc_write",    32'(pc_write),    32'd0);
        check("rst_retired_cnt", 32'(retired_cnt), 32'd0);
        imem_ready = 1'b0;
        rst        = 1'b0;
        #1;
        check("imem_req_after_rst", 32'(imem_req), 32'd1);

        // Directed instructions with literal latencies and running counts.
        run_instr(6'd0, 0, 0, 1'b0, 1'b0, 1'b0, c);
        check("lat_reg", 32'(c), 32'd4);
        check("cnt_after_reg", 32'(model_cnt), 32'd1);
        run_instr(6'd5, 0, 3, 1'b0, 1'b0, 1'b0, c);
        check("lat_load_wait3", 32'(c), 32'd8);
        run_instr(6'd3, 0, 0, 1'b1, 1'b0, 1'b0, c);
        check("lat_br_taken", 32'(c), 32'd3);
        run_instr(6'd3, 0, 0, 1'b0, 1'b0, 1'b0, c);
        check("lat_br_not_taken", 32'(c), 32'd3);
        check("cnt_after_br", 32'(model_cnt), 32'd4);
        run_instr(6'd9, 0, 0, 1'b0, 1'b0, 1'b0, c);
        check("lat_jal", 32'(c), 32'd4);
        run_instr(6'd63, 0, 0, 1'b0, 1'b0, 1'b0, c);
        check("lat_illegal", 32'(c), 32'd2);
        check("cnt_after_illegal", 32'(model_cnt), 32'd5);
        run_instr(6'd6, 0, 0, 1'b0, 1'b0, 1'b0, c);
        check("lat_store", 32'(c), 32'd4);
        run_instr(6'd4, 2, 0, 1'b0, 1'b1, 1'b0, c);
        check("lat_bn_iwait2", 32'(c), 32'd5);

        // Random instruction mix; the 4-bit counter wraps several times.
        run_random(200);
        run_instr(6'd0, 0, 0, 1'b0, 1'b0, 1'b0, c);

        // Store stalled in MEM, then asynchronous reset mid-cycle.
        run_instr(6'd6, 1, 3, 1'b0, 1'b0, 1'b1, c);
        @(negedge clk);
        #2;
        rst        = 1'b1;
        imem_ready = 1'b1;
        #1;
        check("abort_dmem_wr",     32'(dmem_wr),     32'd0);
        check("abort_state",       32'(state),       32'd0);
        check("abort_retired_cnt", 32'(retired_cnt), 32'd0);
        check("abort_imem_req",    32'(imem_req),    32'd0);
        check("abort_ir_write",    32'(ir_write),    32'd0);
        model_cnt = '0;
        @(posedge clk);
        @(negedge clk);
        imem_ready = 1'b0;
        rst        = 1'b0;
        #1;
        check("imem_req_after_abort", 32'(imem_req), 32'd1);

        run_random(30);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
